// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display blocks.
package seg_pkg;

    localparam logic AN_OFF = 1'b1;
    localparam logic AN_ON  = 1'b0;

    // A single-digit display still needs a 1-bit index register.
    function automatic int seg_idx_w(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_tick_div.sv
// Free-running prescaler: cnt walks 0..DIV-1 and tick marks the last count.
module tick_div #(
    parameter int DIV   = 50000,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_W'(DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed scanner for a common-anode 7-segment display with dead time,
// leading-zero blanking and per-digit decimal points; feeds an external BCD7 decoder.
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int DEAD   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [3:0]            digit,
    output logic                  blank,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int IDX_W = seg_idx_w(DIGITS);
    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]    cnt;
    logic                tick;
    logic                in_dead;

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic                blz_q, blz_d;

    logic [3:0]          digit_q, digit_d;
    logic                blank_q, blank_d;
    logic                dp_out_q, dp_out_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic [DIGITS-1:0]   lz_vec;
    logic [3:0]          nib_sel;
    logic                lz_sel;
    logic                dp_sel;

    tick_div #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .cnt   (cnt),
        .tick  (tick)
    );

    generate
        if (DEAD == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (cnt < CNT_W'(DEAD));
        end
    endgenerate

    always_comb begin
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        value_d = load ? value    : value_q;
        dp_d    = load ? dp_in    : dp_q;
        blz_d   = load ? blank_lz : blz_q;
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin : lz_scan
        logic zero_above;
        zero_above = 1'b1;
        lz_vec     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (value_q[4*i +: 4] == 4'h0);
            lz_vec[i]  = blz_q && (i != 0) && zero_above;
        end
    end

    always_comb begin
        nib_sel = 4'h0;
        lz_sel  = 1'b0;
        dp_sel  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel = value_q[4*i +: 4];
                lz_sel  = lz_vec[i];
                dp_sel  = dp_q[i];
            end
        end
    end

    always_comb begin
        digit_d  = nib_sel;
        blank_d  = in_dead || lz_sel;
        dp_out_d = !blank_d && dp_sel;
        an_d     = {DIGITS{AN_OFF}};
        for (int i = 0; i < DIGITS; i++) begin
            if (!blank_d && (idx_q == IDX_W'(i))) begin
                an_d[i] = AN_ON;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q    <= '0;
            value_q  <= '0;
            dp_q     <= '0;
            blz_q    <= 1'b0;
            digit_q  <= 4'h0;
            blank_q  <= 1'b1;
            dp_out_q <= 1'b0;
            an_q     <= {DIGITS{AN_OFF}};
        end else begin
            idx_q    <= idx_d;
            value_q  <= value_d;
            dp_q     <= dp_d;
            blz_q    <= blz_d;
            digit_q  <= digit_d;
            blank_q  <= blank_d;
            dp_out_q <= dp_out_d;
            an_q     <= an_d;
        end
    end

    assign digit = digit_q;
    assign blank = blank_q;
    assign dp    = dp_out_q;
    assign an    = an_q;

endmodule

// File: tb/tb_seg_scan.sv
// Randomised self-checking bench for seg_scan against a cycle-count based display model.
module tb_seg_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int DEAD   = 1;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [3:0]  digit, digit0;
    logic        blank, blank0;
    logic        dp, dp0;
    logic [3:0]  an, an0;

    int checks;
    int errors;

    // model state: cycles since reset release plus the latched register image
    int          m_n;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_blz;
    logic [9:0]  exp_main;
    logic [9:0]  exp_zero;

    seg_scan #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .digit(digit), .blank(blank), .dp(dp), .an(an)
    );

    seg_scan #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(0)) dut0 (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .digit(digit0), .blank(blank0), .dp(dp0), .an(an0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected {an, blank, digit, dp} for the current model state and a given dead time
    function automatic logic [9:0] model(input int dead);
        int         cnt, idx;
        logic [3:0] nib, an_e;
        logic       lz, blk, dpe;
        cnt  = m_n % DIV;
        idx  = (m_n / DIV) % DIGITS;
        nib  = 4'((m_val >> (4 * idx)) & 16'h000F);
        lz   = m_blz && (idx != 0) && ((m_val >> (4 * idx)) == 16'h0000);
        blk  = (cnt < dead) || lz;
        an_e = blk ? 4'hF : 4'(~(4'b0001 << idx));
        dpe  = !blk && m_dp[idx];
        return {an_e, blk, nib, dpe};
    endfunction

    // one clock: predict outputs for this edge, advance model, sample #1 after the edge
    task automatic cycle();
        if (reset) begin
            exp_main = {4'hF, 1'b1, 4'h0, 1'b0};
            exp_zero = exp_main;
            m_n   = 0;
            m_val = '0;
            m_dp  = '0;
            m_blz = 1'b0;
        end else begin
            exp_main = model(DEAD);
            exp_zero = model(0);
            m_n++;
            if (load) begin
                m_val = value;
                m_dp  = dp_in;
                m_blz = blank_lz;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] v,
                                 input logic [3:0] d, input logic b);
        load     = ld;
        value    = v;
        dp_in    = d;
        blank_lz = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b1, 16'hBEEF, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if ({an, blank, digit, dp} !== {4'hF, 1'b1, 4'h0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc %0d got %h exp %h", i, {an, blank, digit, dp}, {4'hF, 1'b1, 4'h0, 1'b0});
            end
        end
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
        cycle();
        checks++;
        if ({an, blank, digit, dp} !== {4'hF, 1'b1, 4'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_release got %h exp %h", {an, blank, digit, dp}, {4'hF, 1'b1, 4'h0, 1'b0});
        end
    endtask

    task automatic test_scan(input logic [15:0] v, input logic [3:0] d, input logic b, input string name);
        applyStimulus(1'b1, v, d, b);
        cycle();
        applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < 2 * DIGITS * DIV; i++) begin
            cycle();
            checks++;
            if ({an, blank, digit, dp} !== exp_main) begin
                errors++;
                $display("[TB] FAIL %s cyc %0d got %h exp %h", name, i, {an, blank, digit, dp}, exp_main);
            end
        end
    endtask

    task automatic test_dp();
        applyStimulus(1'b1, 16'($urandom()), 4'b0100, 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < DIGITS * DIV; i++) begin
            cycle();
            checks++;
            if (dp !== (an == 4'b1011) || {an, blank, digit, dp} !== exp_main) begin
                errors++;
                $display("[TB] FAIL dp cyc %0d got %h exp %h", i, {an, blank, digit, dp}, exp_main);
            end
        end
    endtask

    task automatic test_load_tick();
        int guard;
        guard = 0;
        applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
        while ((m_n % DIV) != DIV - 1 && guard < 2 * DIV) begin
            cycle();
            guard++;
        end
        applyStimulus(1'b1, 16'($urandom()), 4'($urandom()), 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < 2 * DIV; i++) begin
            cycle();
            checks++;
            if ({an, blank, digit, dp} !== exp_main) begin
                errors++;
                $display("[TB] FAIL load_tick cyc %0d got %h exp %h", i, {an, blank, digit, dp}, exp_main);
            end
        end
        while ((m_n % DIV) != 2 && guard < 4 * DIV) begin
            cycle();
            guard++;
        end
        applyStimulus(1'b1, 16'($urandom()), 4'($urandom()), 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < DIV; i++) begin
            cycle();
            checks++;
            if ({an, blank, digit, dp} !== exp_main) begin
                errors++;
                $display("[TB] FAIL load_mid cyc %0d got %h exp %h", i, {an, blank, digit, dp}, exp_main);
            end
        end
    endtask

    task automatic test_reset_mid();
        int  guard;
        bit  seen_lit;
        guard = 0;
        applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
        while (!(((m_n / DIV) % DIGITS) == 2 && (m_n % DIV) == 1) && guard < 4 * DIGITS * DIV) begin
            cycle();
            guard++;
        end
        checks++;
        if (guard >= 4 * DIGITS * DIV) begin
            errors++;
            $display("[TB] FAIL reset_mid_align got %0d exp <%0d", guard, 4 * DIGITS * DIV);
        end
        reset = 1'b1;
        applyStimulus(1'b1, 16'h5555, 4'hF, 1'b0);
        cycle();
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
        seen_lit = 1'b0;
        for (int i = 0; i < 2 * DIGITS * DIV; i++) begin
            cycle();
            checks++;
            if ({an, blank, digit, dp} !== exp_main || {an0, blank0, digit0, dp0} !== exp_zero
                || (seen_lit && an0 == 4'hF)) begin
                errors++;
                $display("[TB] FAIL reset_mid cyc %0d got %h/%h exp %h/%h", i,
                         {an, blank, digit, dp}, {an0, blank0, digit0, dp0}, exp_main, exp_zero);
            end
            if (an0 != 4'hF) seen_lit = 1'b1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 9) == 0), 16'($urandom() & (($urandom_range(0, 1) == 1) ? 32'h00FF : 32'hFFFF)),
                          4'($urandom()), 1'($urandom()));
            cycle();
            checks++;
            if ({an, blank, digit, dp} !== exp_main || {an0, blank0, digit0, dp0} !== exp_zero) begin
                errors++;
                $display("[TB] FAIL random cyc %0d got %h/%h exp %h/%h", i,
                         {an, blank, digit, dp}, {an0, blank0, digit0, dp0}, exp_main, exp_zero);
            end
        end
        applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_n = 0; m_val = '0; m_dp = '0; m_blz = 1'b0;
        applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
        reset = 1'b1;
        test_reset();
        test_scan(16'h12AF, 4'h0, 1'b0, "scan_12af");
        test_scan(16'h0030, 4'h0, 1'b1, "lz_0030");
        test_scan(16'h0000, 4'h0, 1'b1, "lz_zero");
        test_dp();
        test_load_tick();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
